// File: rtl/dest_reg_hazard_tracker_if.sv
// rtl/dest_reg_hazard_tracker_if.sv - ID-stage hazard tracker signal bundle
interface dest_reg_hazard_tracker_if #(
    parameter int REG_W = 5
);
    logic             id_valid;
    logic [REG_W-1:0] id_dest_reg;
    logic             id_reg_write;
    logic             id_mem_read;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             flush;
    logic             stall;
    logic [1:0]       fwd_sel_rs;
    logic [1:0]       fwd_sel_rt;
    logic [REG_W-1:0] wb_dest_reg;
    logic             wb_reg_write;

    modport master (
        output id_valid, id_dest_reg, id_reg_write, id_mem_read,
        output id_rs, id_rt, id_uses_rs, id_uses_rt, flush,
        input  stall, fwd_sel_rs, fwd_sel_rt, wb_dest_reg, wb_reg_write
    );

    modport slave (
        input  id_valid, id_dest_reg, id_reg_write, id_mem_read,
        input  id_rs, id_rt, id_uses_rs, id_uses_rt, flush,
        output stall, fwd_sel_rs, fwd_sel_rt, wb_dest_reg, wb_reg_write
    );
endinterface

// File: rtl/dest_reg_hazard_tracker.sv
// rtl/dest_reg_hazard_tracker.sv - destination shift pipeline with forwarding selects and load-use stall
module dest_reg_hazard_tracker #(
    parameter int DEPTH            = 3,
    parameter int LOAD_STALL_DEPTH = 1,
    parameter int REG_W            = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    dest_reg_hazard_tracker_if.slave bus
);
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] dest;
        logic             reg_write;
        logic             mem_read;
    } entry_t;

    // stage[0] is EX (stage 1), stage[DEPTH-1] is WB
    entry_t           stage [DEPTH];
    logic [DEPTH-1:0] match_rs;
    logic [DEPTH-1:0] match_rt;
    logic [1:0]       sel_rs;
    logic [1:0]       sel_rt;
    logic             haz_rs;
    logic             haz_rt;
    logic             stall_c;
    logic             accept;

    always_comb begin
        match_rs = '0;
        match_rt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match_rs[k] = stage[k].valid && stage[k].reg_write && (stage[k].dest != '0) &&
                          (stage[k].dest == bus.id_rs) && bus.id_uses_rs;
            match_rt[k] = stage[k].valid && stage[k].reg_write && (stage[k].dest != '0) &&
                          (stage[k].dest == bus.id_rt) && bus.id_uses_rt;
        end
    end

    // Scan oldest to youngest so the youngest match overwrites any older one
    always_comb begin
        sel_rs = '0;
        sel_rt = '0;
        haz_rs = 1'b0;
        haz_rt = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match_rs[k]) begin
                sel_rs = 2'(k + 1);
                haz_rs = stage[k].mem_read && (k < LOAD_STALL_DEPTH);
            end
            if (match_rt[k]) begin
                sel_rt = 2'(k + 1);
                haz_rt = stage[k].mem_read && (k < LOAD_STALL_DEPTH);
            end
        end
    end

    assign bus.fwd_sel_rs = haz_rs ? 2'd0 : sel_rs;
    assign bus.fwd_sel_rt = haz_rt ? 2'd0 : sel_rt;
    assign stall_c        = bus.id_valid && !bus.flush && (haz_rs || haz_rt);
    assign bus.stall      = stall_c;
    assign accept         = bus.id_valid && !bus.flush && !stall_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
        end else begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                stage[k] <= stage[k-1];
            end
            stage[0] <= accept ? {1'b1, bus.id_dest_reg, bus.id_reg_write, bus.id_mem_read}
                               : '0;
        end
    end

    assign bus.wb_reg_write = stage[DEPTH-1].valid && stage[DEPTH-1].reg_write;
    assign bus.wb_dest_reg  = stage[DEPTH-1].valid ? stage[DEPTH-1].dest : '0;
endmodule

// File: tb/tb_dest_reg_hazard_tracker.sv
// tb/tb_dest_reg_hazard_tracker.sv - directed scoreboard bench for dest_reg_hazard_tracker
module tb_dest_reg_hazard_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    // expected {wb_reg_write, wb_dest_reg} per issue slot, oldest first
    logic [5:0] sb [$];

    dest_reg_hazard_tracker_if #(.REG_W(5)) bus ();

    dest_reg_hazard_tracker #(
        .DEPTH            (3),
        .LOAD_STALL_DEPTH (1),
        .REG_W            (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [4:0] d, input logic rw, input logic mr,
                         input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic fl);
        bus.id_valid     = v;
        bus.id_dest_reg  = d;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_uses_rs   = urs;
        bus.id_uses_rt   = urt;
        bus.flush        = fl;
    endtask

    task automatic check_wb(input string tag);
        logic [5:0] exp;
        exp = 6'h0;
        if (sb.size() == 3) exp = sb.pop_front();
        chk({tag, "_wb"}, {2'b0, bus.wb_reg_write, bus.wb_dest_reg}, {2'b0, exp});
    endtask

    task automatic step(input string tag, input logic v, input logic [4:0] d,
                        input logic rw, input logic mr,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic fl,
                        input logic es, input logic [1:0] efs, input logic [1:0] eft);
        drive(v, d, rw, mr, rs, rt, urs, urt, fl);
        #1;
        chk({tag, "_stall"}, {7'b0, bus.stall}, {7'b0, es});
        chk({tag, "_fwd_rs"}, {6'b0, bus.fwd_sel_rs}, {6'b0, efs});
        chk({tag, "_fwd_rt"}, {6'b0, bus.fwd_sel_rt}, {6'b0, eft});
        @(posedge clk);
        sb.push_back((v && !fl && !es) ? {rw, d} : 6'h0);
        #1;
        check_wb(tag);
        @(negedge clk);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);
    endtask

    task automatic do_reset(input int n, input string tag);
        rst = 1'b1;
        drive(1'b1, 5'd5, 1'b1, 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_stall"}, {7'b0, bus.stall}, 8'h0);
            chk({tag, "_fwd_rs"}, {6'b0, bus.fwd_sel_rs}, 8'h0);
            chk({tag, "_fwd_rt"}, {6'b0, bus.fwd_sel_rt}, 8'h0);
            chk({tag, "_wb"}, {2'b0, bus.wb_reg_write, bus.wb_dest_reg}, 8'h0);
        end
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        do_reset(2, "reset");

        // tag          v  dest  rw mr  rs  rt  urs urt fl  stall frs frt
        step("alu_w3",   1, 5'd3, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("alu_r1",   1, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0, 2'd1, 2'd0);
        step("alu_r2",   1, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0, 2'd2, 2'd0);
        step("alu_r3",   1, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0, 2'd3, 2'd0);
        step("alu_ret",  1, 5'd0, 0, 0, 5'd3, 5'd0, 1, 0, 0, 0, 2'd0, 2'd0);

        step("yw_a",     1, 5'd7, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("yw_b",     1, 5'd7, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("yw_rd",    1, 5'd0, 0, 0, 5'd0, 5'd7, 0, 1, 0, 0, 2'd0, 2'd1);

        step("lu_ld",    1, 5'd4, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("lu_stl",   1, 5'd8, 1, 0, 5'd4, 5'd0, 1, 0, 0, 1, 2'd0, 2'd0);
        step("lu_go",    1, 5'd8, 1, 0, 5'd4, 5'd0, 1, 0, 0, 0, 2'd2, 2'd0);

        step("r0_w",     1, 5'd0, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("r0_rd",    1, 5'd0, 0, 0, 5'd0, 5'd0, 1, 1, 0, 0, 2'd0, 2'd0);
        step("nu_ld",    1, 5'd9, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("nu_rd",    1, 5'd1, 1, 0, 5'd0, 5'd9, 0, 0, 0, 0, 2'd0, 2'd0);

        step("yo_ld",    1, 5'd5, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("yo_alu",   1, 5'd5, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("yo_rd",    1, 5'd0, 0, 0, 5'd5, 5'd5, 1, 1, 0, 0, 2'd1, 2'd1);

        step("ly_alu",   1, 5'd6, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("ly_ld",    1, 5'd6, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("ly_stl",   1, 5'd2, 0, 0, 5'd0, 5'd6, 0, 1, 0, 1, 2'd0, 2'd0);
        step("ly_go",    1, 5'd2, 0, 0, 5'd0, 5'd6, 0, 1, 0, 0, 2'd0, 2'd2);

        step("nw_w",     1, 5'd11, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("nw_rd",    1, 5'd0, 0, 0, 5'd11, 5'd0, 1, 0, 0, 0, 2'd0, 2'd0);

        step("fl_ld",    1, 5'd2, 1, 1, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        step("fl_rd",    1, 5'd12, 1, 0, 5'd2, 5'd0, 1, 0, 1, 0, 2'd0, 2'd0);
        nop("fl_n1");
        nop("fl_n2");
        nop("fl_n3");

        step("mr_w8",    1, 5'd8, 1, 0, 5'd0, 5'd0, 0, 0, 0, 0, 2'd0, 2'd0);
        do_reset(1, "mid_rst");
        step("mr_rd",    1, 5'd0, 0, 0, 5'd8, 5'd8, 1, 1, 0, 0, 2'd0, 2'd0);
        nop("mr_n1");
        nop("mr_n2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dest_reg_hazard_tracker.md
Name: dest_reg_hazard_tracker

Overview:
- Sits in ID, directly downstream of the 5-bit destination-register select mux (rt/rd choice).
- Captures the selected destination register and write/load flags, and carries them through the downstream stages (EX, MEM, WB, as a shift pipeline).
- Compares the ID-stage source registers against in-flight destinations. Produces per-operand forwarding selects and a load-use stall.
- Presents the WB-stage destination to the register file.

Parameters:
- DEPTH, 3, number of tracked stages after ID (stage1 = EX ... stageDEPTH = WB); legal range 1..3.
- LOAD_STALL_DEPTH, 1, load result unavailable for forwarding while the load sits in stages 1..LOAD_STALL_DEPTH; legal range 0..DEPTH.
- REG_W, 5, register-index width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_dest_reg  in  REG_W  destination from the dest-select mux.
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- id_rs  in  REG_W  source operand A index.
- id_rt  in  REG_W  source operand B index.
- id_uses_rs  in  1  operand A is read.
- id_uses_rt  in  1  operand B is read.
- flush  in  1  kill the ID instruction (branch taken / redirect).
- stall  out  1  load-use hazard; hold IF/ID.
- fwd_sel_rs  out  2  0 = regfile, k = forward from stage k (1..DEPTH).
- fwd_sel_rt  out  2  same encoding for operand B.
- wb_dest_reg  out  REG_W  destination of stage DEPTH.
- wb_reg_write  out  1  stage DEPTH valid and writes.

Behaviour:
- Storage: DEPTH entries, each holding {valid, dest[REG_W], reg_write, mem_read}.
- Stage k "matches" source s when all of the following hold:
  - valid_k and reg_write_k;
  - dest_k != 0;
  - dest_k == s;
  - the corresponding uses_* input is 1.
- Register 0 never matches.
- Forwarding (combinational, 0-cycle):
  - fwd_sel = the smallest k that matches (youngest wins); 0 if none.
  - If that youngest match is a load with k <= LOAD_STALL_DEPTH, fwd_sel = 0 and the hazard is flagged.
- stall (combinational):
  - Asserted when id_valid = 1, flush = 0, and either operand's youngest match is a flagged load hazard.
  - An older match never stalls if a younger non-load match exists.
  - stall is 0 whenever flush = 1.
- Update on each rising edge with rst = 0:
  - Stages shift: stage k+1 <= stage k, for k = 1..DEPTH-1.
  - The backend never stalls.
  - stage1 <= {1, id_dest_reg, id_reg_write, id_mem_read} if id_valid & !flush & !stall; otherwise stage1 <= bubble (all fields 0).
- A stalled ID instruction is re-presented by upstream the next cycle. stall drops once the load moves past stage LOAD_STALL_DEPTH.
- wb_dest_reg / wb_reg_write are driven directly from stage DEPTH registers (registered; DEPTH-cycle latency from ID acceptance).
  - wb_dest_reg = 0 when that stage is invalid.
- Reset: on rst = 1 at a clock edge, all entries are cleared (valid = 0, fields 0).
  - Consequently stall = 0, fwd_sel_* = 0, wb_dest_reg = 0, wb_reg_write = 0.
  - rst mid-stream discards all in-flight entries; no partial shift occurs that cycle.
- Simultaneous flush and hazard: flush wins; a bubble is inserted and stall = 0.
- id_reg_write = 0 with nonzero id_dest_reg: the entry is tracked but never matches.

Test Plan:
- Reset: hold rst 2 cycles with id_valid = 1 and dest = 5 → stall = 0, fwd_sel_rs/rt = 0, wb_dest_reg = 0, wb_reg_write = 0; release → first accepted instruction appears at wb after 3 cycles.
- ALU back-to-back: issue write r3, then next cycle read rs = r3 → fwd_sel_rs = 1. One cycle later (intervening nop) → fwd_sel_rs = 2. Then 3. Then 0 once retired.
- Youngest wins: write r7, write r7, then read rt = r7 → fwd_sel_rt = 1, not 2.
- Load-use: load r4 (mem_read = 1), then read rs = r4 → stall = 1 for exactly 1 cycle, a bubble enters stage1, then fwd_sel_rs = 2 with stall = 0.
- r0 and disabled use: write r0, then read rs = r0 → fwd_sel_rs = 0. Load r9, then read rt = r9 with id_uses_rt = 0 → stall = 0.
- Flush priority: load r2, then a dependent read with flush = 1 → stall = 0, stage1 bubble, wb_reg_write = 0 for that slot 3 cycles later.
